// File: rtl/cpu_pkg.sv
// Shared encodings for the 4-bit processor: opcode prefixes, register indices
// and the immediate source code used by the instruction decoder and datapath.
package cpu_pkg;

   localparam int REG_EN_W = 9;

   // Opcode prefixes, matched against the top bits of the instruction word
   localparam logic       LOAD = 1'b0;
   localparam logic [1:0] MOVE = 2'b10;
   localparam logic [2:0] ALU  = 3'b110;
   localparam logic [3:0] JMP  = 4'b1110;
   localparam logic [3:0] JNZ  = 4'b1111;

   // Destination (reg_en bit) and source (source_sel) indices
   localparam int EN_X0   = 0;
   localparam int EN_X1   = 1;
   localparam int EN_Y0   = 2;
   localparam int EN_Y1   = 3;
   localparam int EN_OREG = 4;
   localparam int EN_M    = 5;
   localparam int EN_I    = 6;
   localparam int EN_DM   = 7;
   localparam int EN_R    = 8;

   localparam logic [3:0] SRC_X0  = 4'd0;
   localparam logic [3:0] SRC_X1  = 4'd1;
   localparam logic [3:0] SRC_Y0  = 4'd2;
   localparam logic [3:0] SRC_Y1  = 4'd3;
   localparam logic [3:0] SRC_R   = 4'd4;
   localparam logic [3:0] SRC_M   = 4'd5;
   localparam logic [3:0] SRC_I   = 4'd6;
   localparam logic [3:0] SRC_DM  = 4'd7;
   localparam logic [3:0] SRC_IMM = 4'd8;

endpackage

// File: rtl/instruction_decoder.sv
// Zero-latency decoder for the 8-bit program word; owns the zero flag,
// the instruction register and a saturating taken-jump counter.
module instruction_decoder
   import cpu_pkg::*;
(
   input  logic                clk,
   input  logic                sync_reset,
   input  logic [7:0]          pm_data,
   input  logic                alu_out_eq_0,
   output logic                jmp,
   output logic                jmp_nz,
   output logic [3:0]          jmp_addr,
   output logic                dont_jmp,
   output logic [REG_EN_W-1:0] reg_en,
   output logic [3:0]          source_sel,
   output logic                x_sel,
   output logic                y_sel,
   output logic [2:0]          alu_func,
   output logic [7:0]          ir,
   output logic [7:0]          jmp_count,
   output logic [7:0]          from_ID
);

   logic valid;
   logic z_flag;
   logic gate;
   logic alu_dec;
   logic taken;

   // Outputs stay quiet during reset and the first cycle after it, while
   // program memory is still returning the word for address zero.
   assign gate     = valid & ~sync_reset;
   assign jmp_addr = pm_data[3:0];
   assign dont_jmp = z_flag;
   assign from_ID  = ir;

   always_comb begin
      reg_en     = '0;
      source_sel = '0;
      x_sel      = 1'b0;
      y_sel      = 1'b0;
      alu_func   = '0;
      jmp        = 1'b0;
      jmp_nz     = 1'b0;
      alu_dec    = 1'b0;
      if (gate) begin
         if (pm_data[7] == LOAD) begin
            reg_en[pm_data[6:4]] = 1'b1;
            source_sel           = SRC_IMM;
         end else if (pm_data[7:6] == MOVE) begin
            // A move onto itself is the NOP encoding
            if (pm_data[5:3] != pm_data[2:0])
               reg_en[pm_data[5:3]] = 1'b1;
            source_sel = {1'b0, pm_data[2:0]};
         end else if (pm_data[7:5] == ALU) begin
            reg_en[EN_R] = 1'b1;
            x_sel        = pm_data[4];
            y_sel        = pm_data[3];
            alu_func     = pm_data[2:0];
            alu_dec      = 1'b1;
         end else if (pm_data[7:4] == JMP) begin
            jmp = 1'b1;
         end else begin
            jmp_nz = 1'b1;
         end
      end
   end

   assign taken = jmp | (jmp_nz & ~z_flag);

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         valid     <= 1'b0;
         z_flag    <= 1'b0;
         ir        <= '0;
         jmp_count <= '0;
      end else begin
         valid <= 1'b1;
         ir    <= pm_data;
         if (alu_dec)
            z_flag <= alu_out_eq_0;
         if (taken && jmp_count != 8'hFF)
            jmp_count <= jmp_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed-vector bench for instruction_decoder with a queue-based scoreboard.
module tb_instruction_decoder;

   logic       clk = 1'b0;
   logic       sync_reset;
   logic [7:0] pm_data;
   logic       alu_out_eq_0;
   logic       jmp, jmp_nz, dont_jmp, x_sel, y_sel;
   logic [3:0] jmp_addr, source_sel;
   logic [8:0] reg_en;
   logic [2:0] alu_func;
   logic [7:0] ir, jmp_count, from_ID;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      nm;
      logic [8:0] en;
      logic [3:0] src;
      logic       xs, ys;
      logic [2:0] fn;
      logic       j, jn, dj;
      logic [3:0] addr;
      logic [7:0] cnt;
      logic [7:0] ir;
   } exp_t;

   exp_t sb[$];

   logic [7:0] prev_pm;
   logic       prev_rst;

   instruction_decoder dut (
      .clk(clk), .sync_reset(sync_reset), .pm_data(pm_data),
      .alu_out_eq_0(alu_out_eq_0), .jmp(jmp), .jmp_nz(jmp_nz),
      .jmp_addr(jmp_addr), .dont_jmp(dont_jmp), .reg_en(reg_en),
      .source_sel(source_sel), .x_sel(x_sel), .y_sel(y_sel),
      .alu_func(alu_func), .ir(ir), .jmp_count(jmp_count), .from_ID(from_ID)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input string fld,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, exp);
      end
   endtask

   // Monitor: compares the live outputs mid-cycle against the oldest expectation
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk(e.nm, "reg_en",     32'(reg_en),     32'(e.en));
         chk(e.nm, "source_sel", 32'(source_sel), 32'(e.src));
         chk(e.nm, "x_sel",      32'(x_sel),      32'(e.xs));
         chk(e.nm, "y_sel",      32'(y_sel),      32'(e.ys));
         chk(e.nm, "alu_func",   32'(alu_func),   32'(e.fn));
         chk(e.nm, "jmp",        32'(jmp),        32'(e.j));
         chk(e.nm, "jmp_nz",     32'(jmp_nz),     32'(e.jn));
         chk(e.nm, "dont_jmp",   32'(dont_jmp),   32'(e.dj));
         chk(e.nm, "jmp_addr",   32'(jmp_addr),   32'(e.addr));
         chk(e.nm, "jmp_count",  32'(jmp_count),  32'(e.cnt));
         chk(e.nm, "ir",         32'(ir),         32'(e.ir));
         chk(e.nm, "from_ID",    32'(from_ID),    32'(e.ir));
      end
   end

   // Drive one cycle's inputs just after the edge and queue what the outputs
   // must be for that cycle (state values are those set by the edge just passed).
   task automatic step(input string nm, input logic [7:0] pm, input logic eq,
                       input logic rst, input logic [8:0] en, input logic [3:0] src,
                       input logic xs, input logic ys, input logic [2:0] fn,
                       input logic j, input logic jn, input logic dj,
                       input logic [7:0] cnt);
      exp_t e;
      @(posedge clk);
      #1;
      sync_reset   = rst;
      pm_data      = pm;
      alu_out_eq_0 = eq;
      e.nm = nm; e.en = en; e.src = src; e.xs = xs; e.ys = ys; e.fn = fn;
      e.j = j; e.jn = jn; e.dj = dj; e.addr = pm[3:0]; e.cnt = cnt;
      e.ir = prev_rst ? 8'h00 : prev_pm;
      prev_pm  = pm;
      prev_rst = rst;
      sb.push_back(e);
   endtask

   initial begin
      sync_reset   = 1'b1;
      pm_data      = 8'hE5;
      alu_out_eq_0 = 1'b0;
      prev_pm      = 8'hE5;
      prev_rst     = 1'b1;

      //    name         pm     eq    rst   reg_en  src   x     y     fn    jmp   jnz   dj    cnt
      step("rst0",      8'hE5, 1'b0, 1'b1, 9'h000, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      step("rst1",      8'hE5, 1'b0, 1'b1, 9'h000, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      step("post_rst",  8'hE5, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      step("jmp_e5",    8'hE5, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
      step("ld_y1",     8'h3A, 1'b0, 1'b0, 9'h008, 4'd8, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1);
      step("mv_nop",    8'h9B, 1'b0, 1'b0, 9'h000, 4'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1);
      step("alu_z1",    8'hC9, 1'b1, 1'b0, 9'h100, 4'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1);
      step("jnz_nt",    8'hF3, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'd1);
      step("alu_z0",    8'hC9, 1'b0, 1'b0, 9'h100, 4'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 8'd1);
      step("jnz_tk",    8'hF3, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd1);
      step("ld_x0",     8'h00, 1'b0, 1'b0, 9'h001, 4'd8, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd2);
      step("mv_x1_r",   8'h8C, 1'b0, 1'b0, 9'h002, 4'd4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd2);
      step("alu_x1f6",  8'hD6, 1'b0, 1'b0, 9'h100, 4'd0, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 8'd2);

      // Count starts at 2 and must stop at FF
      for (int k = 0; k < 300; k++) begin
         int c;
         c = (2 + k > 255) ? 255 : 2 + k;
         step("sat", 8'hE0, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'(c));
      end

      step("alu_z1b",   8'hC9, 1'b1, 1'b0, 9'h100, 4'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'hFF);
      step("mid_rst",   8'hF3, 1'b0, 1'b1, 9'h000, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'hFF);
      step("rel_rst",   8'hF3, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      step("jnz_rst",   8'hF3, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd0);
      step("after_jnz", 8'h00, 1'b0, 1'b0, 9'h001, 4'd8, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1);

      // Drain the scoreboard with a bounded wait
      for (int w = 0; w < 10 && sb.size() > 0; w++)
         @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
